aes_decipher_iter: RTL and testbench
====================================

AES_DECIPHER_ITER -- requirements
Module: aes_decipher_iter

Interface
- REQ-001 The block SHALL have parameter KEYLEN_SUPPORT, default 3'b111, a bitmask of accepted key lengths: bit0 = 128, bit1 = 192, bit2 = 256.
- REQ-002 The block SHALL have parameter CLEAR_ON_ABORT, default 1: when 1, reset clears new_block; when 0, new_block is left unreset.
- REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
- REQ-005 Port next, input, 1 bit: start request, sampled on clk rising edge.
- REQ-006 Port keylen, input, 2 bits: 0 = 128-bit (Nr=10), 1 = 192-bit (Nr=12), 2 = 256-bit (Nr=14), 3 = reserved.
- REQ-007 Port block, input, 128 bits: ciphertext, byte 0 in bits 127:120, column-major.
- REQ-008 Port round, output, 4 bits: index of the round key required in the current cycle.
- REQ-009 Port round_key, input, 128 bits: round key for index round, valid combinationally in the same cycle.
- REQ-010 Port new_block, output, 128 bits: plaintext result register.
- REQ-011 Port ready, output, 1 bit: high when idle and new_block holds the latest result.
- REQ-012 Port key_err, output, 1 bit: one-cycle pulse when a start is rejected.

Function
- REQ-013 The FSM SHALL have the states IDLE, INIT, MAIN and FINAL; ready SHALL be 1 only in IDLE.
- REQ-014 In IDLE, with next=1 and keylen supported, the block SHALL:
  - latch block and Nr;
  - set round=Nr;
  - go to INIT and drop ready at that edge.
- REQ-015 In IDLE, with next=1 and keylen unsupported (reserved, or its KEYLEN_SUPPORT bit is 0), the block SHALL:
  - stay in IDLE with ready=1;
  - pulse key_err for exactly one cycle;
  - leave new_block unchanged.
- REQ-016 INIT SHALL perform state = state XOR round_key, where round=Nr, in one cycle, then decrement round and go to MAIN.
- REQ-017 MAIN SHALL perform InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns per FIPS-197, decrementing round after each round, until round reaches 0.
- REQ-018 FINAL SHALL perform InvShiftRows, InvSubBytes and AddRoundKey with round=0.
- REQ-019 On FINAL completion, the block SHALL write new_block, return to IDLE and raise ready at the same edge.
- REQ-020 new_block SHALL hold its previous value throughout an operation and SHALL change only at the completion edge.
- REQ-021 next asserted while ready=0 SHALL be ignored, with no queuing and no key_err.
- REQ-022 block, keylen and next SHALL be don't-care outside the acceptance cycle; changes during an operation SHALL NOT affect the result.
- REQ-023 round SHALL be 0 in IDLE.
- REQ-024 Latency without the Configuration macro SHALL be Nr+1 cycles from the acceptance edge to ready=1: 11, 13 or 15.
- REQ-025 next held high continuously SHALL start a new operation on the first edge at which ready=1, i.e. back-to-back operation with no idle gap.

Reset
- REQ-026 When reset_n=0, the block SHALL asynchronously set state=IDLE, ready=1, round=0 and key_err=0.
- REQ-027 When reset_n=0, the working state register SHALL be cleared to 0.
- REQ-028 When reset_n=0, new_block SHALL be cleared to 0 if CLEAR_ON_ABORT=1.
- REQ-029 Reset asserted mid-operation SHALL abort the operation with no partial result written to new_block.
- REQ-030 The first start after reset_n deasserts SHALL be accepted no earlier than the first rising edge with reset_n=1.

Configuration
- REQ-031 The block SHALL use the macro AES_DECIPHER_ITER_SBOX_SHARE_EN to select the InvSubBytes implementation.
- REQ-032 With AES_DECIPHER_ITER_SBOX_SHARE_EN undefined, the block SHALL instantiate 16 aes_inv_sbox instances and complete each MAIN or FINAL round in 1 cycle.
- REQ-033 With AES_DECIPHER_ITER_SBOX_SHARE_EN defined, the block SHALL:
  - instantiate 4 aes_inv_sbox instances;
  - substitute one column per cycle (columns 0 to 3);
  - take 4 cycles per MAIN/FINAL round;
  - hold round constant across those 4 cycles;
  - apply AddRoundKey and InvMixColumns on the 4th cycle.
- REQ-034 Latency with the macro defined SHALL be 4*Nr+1 cycles: 41, 49 or 57.
- REQ-035 All other behaviour SHALL be identical with and without the macro.

Verification
- REQ-036 AES-128: ct 69c4e0d86a7b0430d8cdb78070b4c55a with FIPS-197 C.1 key schedule -> new_block = 00112233445566778899aabbccddeeff; ready after 11 cycles (41 when shared).
- REQ-037 AES-192: ct dda97ca4864cdfe06eaf70a0ec0d7191 with C.2 schedule -> new_block = 00112233445566778899aabbccddeeff; ready after 13/49 cycles; round sequence 12,11,...,0.
- REQ-038 AES-256: ct 8ea2b7ca516745bfeafc49904b496089 with C.3 schedule -> same plaintext; ready after 15/57 cycles.
- REQ-039 keylen=3, or keylen=1 with KEYLEN_SUPPORT=3'b101 -> key_err high for 1 cycle, ready stays 1, new_block unchanged.
- REQ-040 Busy and back-to-back operation:
  - next pulsed mid-operation, with block changed to all-ones -> ignored; result matches REQ-036;
  - next held high -> second operation accepted at the ready edge.
- REQ-041 reset_n pulsed low at cycle 5 of an AES-128 operation -> ready=1, round=0 and new_block=0 immediately; the next operation completes correctly.

Source files
------------

// File: rtl/aes_decipher_iter.sv
// aes_decipher_iter: iterative AES-128/192/256 decipher; round keys are fetched by index via round/round_key.
// Define AES_DECIPHER_ITER_SBOX_SHARE_EN to share 4 inverse S-boxes over 4 cycles per round.
package aes_decipher_iter_pkg;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
endpackage

module aes_inv_sbox (
  input  logic [7:0] i_x,
  output logic [7:0] o_y
);
  import aes_decipher_iter_pkg::*;
  logic [7:0] w_a, w_2, w_3, w_6, w_12, w_15, w_30, w_60, w_120, w_240, w_252;
  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
    return r ^ 8'h05;
  endfunction
  // multiplicative inverse as a^254 (maps 0 to 0)
  assign w_a   = inv_affine(i_x);
  assign w_2   = gmul(w_a, w_a);
  assign w_3   = gmul(w_2, w_a);
  assign w_6   = gmul(w_3, w_3);
  assign w_12  = gmul(w_6, w_6);
  assign w_15  = gmul(w_12, w_3);
  assign w_30  = gmul(w_15, w_15);
  assign w_60  = gmul(w_30, w_30);
  assign w_120 = gmul(w_60, w_60);
  assign w_240 = gmul(w_120, w_120);
  assign w_252 = gmul(w_240, w_12);
  assign o_y   = gmul(w_252, w_2);
endmodule

module aes_decipher_iter #(
  parameter logic [2:0] KEYLEN_SUPPORT = 3'b111,
  parameter bit         CLEAR_ON_ABORT = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic [1:0]   keylen,
  input  logic [127:0] block,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [127:0] new_block,
  output logic         ready,
  output logic         key_err
);
  import aes_decipher_iter_pkg::*;
  localparam logic [1:0] S_IDLE = 2'd0, S_INIT = 2'd1, S_MAIN = 2'd2, S_FINAL = 2'd3;
  logic [1:0]   r_fsm;
  logic [127:0] r_state;
  logic [3:0]   r_round;
  logic         r_key_err;
  logic [127:0] r_new_block;
  logic [3:0]   w_sup;
  logic         w_key_ok;
  logic [3:0]   w_nr;
  logic [127:0] w_isr, w_sub, w_ark, w_imc;
  logic         w_step, w_done;

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] t;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
    return t;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] t;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127 - 32*c -: 32];
      t[127 - 32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return t;
  endfunction

  // keylen 3 is reserved, so it maps onto a permanently clear support bit
  assign w_sup     = {1'b0, KEYLEN_SUPPORT};
  assign w_key_ok  = w_sup[keylen];
  assign w_nr      = 4'd10 + {1'b0, keylen, 1'b0};
  assign w_isr     = inv_shift_rows(r_state);
  assign w_ark     = w_sub ^ round_key;
  assign w_imc     = inv_mix_columns(w_ark);
  assign w_done    = (r_fsm == S_FINAL) && w_step;
  assign round     = r_round;
  assign ready     = (r_fsm == S_IDLE);
  assign key_err   = r_key_err;
  assign new_block = r_new_block;

`ifdef AES_DECIPHER_ITER_SBOX_SHARE_EN
  logic [1:0]  r_col;
  logic [127:0] r_sub;
  logic [6:0]  w_base;
  logic [31:0] w_col_out;
  // one shift-rowed column per cycle; the round commits once column 3 is substituted
  assign w_base = 7'd127 - {r_col, 5'd0};
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_inv_sbox u_sbox (.i_x(w_isr[w_base - 7'(8*i) -: 8]), .o_y(w_col_out[31 - 8*i -: 8]));
  end
  always_comb begin
    w_sub = r_sub;
    w_sub[w_base -: 32] = w_col_out;
  end
  assign w_step = (r_col == 2'd3);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_col <= '0;
      r_sub <= '0;
    end else if (r_fsm == S_MAIN || r_fsm == S_FINAL) begin
      r_col <= r_col + 2'd1;
      r_sub <= w_sub;
    end else begin
      r_col <= '0;
    end
`else
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (.i_x(w_isr[8*i +: 8]), .o_y(w_sub[8*i +: 8]));
  end
  assign w_step = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_fsm     <= S_IDLE;
      r_state   <= '0;
      r_round   <= '0;
      r_key_err <= 1'b0;
    end else begin
      r_key_err <= (r_fsm == S_IDLE) && next && !w_key_ok;
      case (r_fsm)
        S_IDLE:
          if (next && w_key_ok) begin
            r_state <= block;
            r_round <= w_nr;
            r_fsm   <= S_INIT;
          end
        S_INIT: begin
          r_state <= r_state ^ round_key;
          r_round <= r_round - 4'd1;
          r_fsm   <= S_MAIN;
        end
        S_MAIN:
          if (w_step) begin
            r_state <= w_imc;
            r_round <= r_round - 4'd1;
            r_fsm   <= (r_round == 4'd1) ? S_FINAL : S_MAIN;
          end
        S_FINAL:
          if (w_step) r_fsm <= S_IDLE;
        default: r_fsm <= S_IDLE;
      endcase
    end

  if (CLEAR_ON_ABORT) begin : g_nb_rst
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_new_block <= '0;
      else if (w_done) r_new_block <= w_ark;
  end else begin : g_nb_keep
    always_ff @(posedge clk)
      if (w_done) r_new_block <= w_ark;
  end
endmodule

// File: tb/tb_aes_decipher_iter.sv
// tb_aes_decipher_iter: scoreboard bench; known-answer vectors plus random round keys against a byte-level AES model.
`timescale 1ns/1ps
module tb_aes_decipher_iter;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 0, reset_n = 1, next = 0, next2 = 0;
  logic [1:0] keylen = 0;
  logic [127:0] block = '0;
  logic [3:0] round, round2;
  logic [127:0] round_key, round_key2, new_block, new_block2;
  logic ready, ready2, key_err, key_err2;
  logic [127:0] rk [0:15];
  logic [7:0] sb [0:255];
  logic [7:0] isb [0:255];
  typedef struct { logic [127:0] pt; int nr; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;
  assign round_key  = rk[round];
  assign round_key2 = rk[round2];

  aes_decipher_iter dut (
    .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen), .block(block),
    .round(round), .round_key(round_key), .new_block(new_block), .ready(ready), .key_err(key_err));
  aes_decipher_iter #(.KEYLEN_SUPPORT(3'b101)) dut2 (
    .clk(clk), .reset_n(reset_n), .next(next2), .keylen(keylen), .block(block),
    .round(round2), .round_key(round_key2), .new_block(new_block2), .ready(ready2), .key_err(key_err2));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic int lat_of(input int nr);
`ifdef AES_DECIPHER_ITER_SBOX_SHARE_EN
    return 4 * nr + 1;
`else
    return nr + 1;
`endif
  endfunction

  function automatic int exp_round(input int nr, input int c);
`ifdef AES_DECIPHER_ITER_SBOX_SHARE_EN
    return (c == 0) ? nr : nr - ((c - 1) / 4 + 1);
`else
    return nr - c;
`endif
  endfunction

  // textbook inverse cipher over a 16-byte array, index 4*col+row
  function automatic logic [127:0] ref_dec(input logic [127:0] ct, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ rk[nr][127 - 8*i -: 8];
    for (int k = nr - 1; k >= 0; k--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c + r] = isb[s[4*((c + 4 - r) % 4) + r]] ^ rk[k][127 - 8*(4*c + r) -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c + r] = (k == 0) ? t[4*c + r] :
            gm(t[4*c + r], 8'h0e) ^ gm(t[4*c + (r + 1) % 4], 8'h0b) ^
            gm(t[4*c + (r + 2) % 4], 8'h0d) ^ gm(t[4*c + (r + 3) % 4], 8'h09);
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  // FIPS-197 key expansion for the appendix C keys 00 01 02 ...
  task automatic expand(input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)};
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int j = 0; j <= nk + 6; j++) rk[j] = {w[4*j], w[4*j + 1], w[4*j + 2], w[4*j + 3]};
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_ready: ready=%b expected 1 within 400 cycles", ready);
    end
  endtask

  task automatic start_op(input logic [1:0] kl, input logic [127:0] blk, input logic [127:0] pt);
    wait_ready();
    keylen = kl;
    block = blk;
    next = 1;
    exp_q.push_back('{pt, 10 + 2 * int'(kl)});
    @(negedge clk);
    next = 0;
    keylen = 2'($urandom);
    block = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // monitor: tracks each busy period and scores it when ready returns
  logic prev_rdy = 1;
  int cnt = 0, cur_nr = 10;
  bit seq_ok, hold_ok;
  logic [127:0] held;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_rdy = 1;
      exp_q.delete();
    end else begin
      if (!ready) begin
        if (prev_rdy) begin
          cnt = 0;
          seq_ok = 1;
          hold_ok = 1;
          held = new_block;
          cur_nr = 10;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_start: ready=0 expected 1 (no operation issued)");
          end else cur_nr = exp_q[0].nr;
        end
        if (int'(round) != exp_round(cur_nr, cnt)) seq_ok = 0;
        if (new_block !== held) hold_ok = 0;
        cnt++;
      end else if (!prev_rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done: result %h with no expected entry", new_block);
        end else begin
          e = exp_q.pop_front();
          chk("plaintext", new_block, e.pt);
          chk("latency", 128'(cnt), 128'(lat_of(e.nr)));
          chk("round_seq", 128'(seq_ok), 128'(1));
          chk("hold", 128'(hold_ok), 128'(1));
        end
      end
      prev_rdy = ready;
    end
  end

  initial begin
    logic [7:0] v, b;
    logic [1:0] kl;
    logic [127:0] blk, held_nb;
    for (int x = 0; x < 256; x++) begin
      v = 0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      b = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
      sb[x] = b;
      isb[b] = 8'(x);
    end
    for (int i = 0; i < 16; i++) rk[i] = '0;
    #1 reset_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(ready), 128'(1));
    chk("rst_round", 128'(round), 128'(0));
    chk("rst_key_err", 128'(key_err), 128'(0));
    chk("rst_new_block", new_block, 128'(0));
    reset_n = 1;

    expand(4);
    start_op(2'd0, CT128, PT);
    wait_ready();
    expand(6);
    start_op(2'd1, CT192, PT);
    wait_ready();
    expand(8);
    start_op(2'd2, CT256, PT);
    wait_ready();
    chk("idle_round", 128'(round), 128'(0));

    held_nb = new_block;
    keylen = 2'd3;
    next = 1;
    @(negedge clk);
    next = 0;
    chk("kerr_pulse", 128'(key_err), 128'(1));
    chk("kerr_ready", 128'(ready), 128'(1));
    @(negedge clk);
    chk("kerr_clear", 128'(key_err), 128'(0));
    chk("kerr_nb", new_block, held_nb);

    keylen = 2'd1;
    next2 = 1;
    @(negedge clk);
    next2 = 0;
    chk("kerr2_pulse", 128'(key_err2), 128'(1));
    chk("kerr2_ready", 128'(ready2), 128'(1));
    @(negedge clk);
    chk("kerr2_clear", 128'(key_err2), 128'(0));
    keylen = 2'd2;
    next2 = 1;
    @(negedge clk);
    next2 = 0;
    chk("accept2_ready", 128'(ready2), 128'(0));
    chk("accept2_kerr", 128'(key_err2), 128'(0));

    wait_ready();
    expand(4);
    start_op(2'd0, CT128, PT);
    repeat (2) @(negedge clk);
    block = '1;
    keylen = 2'd0;
    next = 1;
    @(negedge clk);
    keylen = 2'd3;
    @(negedge clk);
    next = 0;
    chk("busy_kerr", 128'(key_err), 128'(0));

    wait_ready();
    keylen = 2'd0;
    block = CT128;
    next = 1;
    exp_q.push_back('{PT, 10});
    exp_q.push_back('{PT, 10});
    wait_ready();
    @(negedge clk);
    chk("b2b_accept", 128'(ready), 128'(0));
    next = 0;

    start_op(2'd0, CT128, PT);
    repeat (3) @(negedge clk);
    #1 reset_n = 0;
    #1;
    chk("abort_ready", 128'(ready), 128'(1));
    chk("abort_round", 128'(round), 128'(0));
    chk("abort_nb", new_block, 128'(0));
    @(negedge clk);
    #1 reset_n = 1;
    start_op(2'd0, CT128, PT);

    for (int k = 0; k < 6; k++) begin
      wait_ready();
      for (int j = 0; j < 16; j++) rk[j] = {$urandom, $urandom, $urandom, $urandom};
      kl = 2'($urandom_range(0, 2));
      blk = {$urandom, $urandom, $urandom, $urandom};
      start_op(kl, blk, ref_dec(blk, 10 + 2 * int'(kl)));
    end
    wait_ready();
    repeat (2) @(negedge clk);
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
